// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared types and constants for the FIFO burst reader.
//   state_t    : burst FSM states
//   SKID_DEPTH : entries in the output skid buffer (covers one cycle of FIFO
//                read latency plus one stalled byte)
//   occ_t      : skid occupancy type (0..SKID_DEPTH)
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
// Valid/ready byte stream leaving the burst reader.
//   out_data  : stream data
//   out_valid : stream valid
//   out_ready : downstream ready; transfer when out_valid && out_ready
// Modports: master (reader side), slave (downstream consumer).
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order buffer between the FIFO read data and the output stream.
//   clk, rst : clock, async active-high reset
//   wr_en    : write wr_data at the tail
//   pop      : remove the head (only when occ > 0)
//   rd_data  : head entry (entry 0)
//   occ      : number of valid entries
// Writing into a full buffer without a simultaneous pop is prevented upstream.
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] ent0, ent1;

    assign rd_data = ent0;

    // ent0 only changes on a pop or when the buffer was empty, so the head
    // stays stable while the stream is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            occ  <= '0;
        end else begin
            case ({wr_en, pop})
                2'b10: begin
                    if (occ == '0) ent0 <= wr_data;
                    else           ent1 <= wr_data;
                    occ <= occ + occ_t'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - occ_t'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; new byte lands behind the survivor.
                    if (occ == occ_t'(1)) begin
                        ent0 <= wr_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drains a requested number of bytes from a byte FIFO and streams them out on
// a valid/ready interface, pulsing done once the last byte is accepted.
//   clk_read     : clock
//   rst          : async active-high reset, aborts any burst
//   start        : begin a burst (only honoured in IDLE)
//   burst_len    : byte count sampled with start; 0 means 2**LEN_WIDTH
//   busy         : burst in progress
//   done         : one-cycle pulse after the final transfer
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : FIFO pop (combinational)
//   fifo_rd_data : FIFO data, valid the cycle after a pop
//   strm         : output stream (fifo_burst_reader_if.master)
//   underrun_cnt : only with FIFO_RD_STATS_EN; saturating count of RUN cycles
//                  that wanted a byte but found the FIFO empty
// Optional feature macro: FIFO_RD_STATS_EN
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_read,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    fifo_burst_reader_if.master   strm
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    localparam int CNT_W = LEN_WIDTH + 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pop_left, xfer_left, len_ext;
    logic             inflight;
    occ_t             occ, pending;
    logic             xfer, pop_nz, room;

    assign len_ext = (burst_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}}
                                       : {1'b0, burst_len};

    assign xfer    = strm.out_valid && strm.out_ready;
    assign pop_nz  = (pop_left != '0);
    // Bytes already committed to the skid buffer: stored plus the one whose
    // FIFO data arrives next cycle. A same-cycle transfer frees a slot.
    assign pending = occ + occ_t'(inflight);
    assign room    = (pending < occ_t'(SKID_DEPTH)) || xfer;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                fifo_rd_en = pop_nz && !fifo_empty && room;
                if (!pop_nz || (pop_left == CNT_W'(1) && fifo_rd_en))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Leave on the final transfer so done follows it directly.
                if (xfer_left == '0 || (xfer_left == CNT_W'(1) && xfer))
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_read or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pop_left  <= '0;
            xfer_left <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            if (state == IDLE && start) begin
                pop_left  <= len_ext;
                xfer_left <= len_ext;
            end else begin
                if (fifo_rd_en) pop_left  <= pop_left - CNT_W'(1);
                if (xfer)       xfer_left <= xfer_left - CNT_W'(1);
            end
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk_read),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (fifo_rd_data),
        .pop     (xfer),
        .rd_data (strm.out_data),
        .occ     (occ)
    );

    assign strm.out_valid = (occ != '0);

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk_read or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (state == IDLE && start) begin
            underrun_cnt <= '0;
        end else if (state == RUN && pop_nz && fifo_empty && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Scoreboard bench: each burst pushes its expected bytes into exp_q; a forked
// monitor pops and compares on every stream transfer. A simple array FIFO
// model supplies data with one-cycle read latency.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    logic       clk_read = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] burst_len;
    logic       busy, done;
    logic       fifo_empty, fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] underrun_cnt;
`endif

    fifo_burst_reader_if #(.DATA_WIDTH(8)) strm ();

    fifo_burst_reader #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .clk_read     (clk_read),
        .rst          (rst),
        .start        (start),
        .burst_len    (burst_len),
        .busy         (busy),
        .done         (done),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .strm         (strm.master)
`ifdef FIFO_RD_STATS_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk_read = ~clk_read;

    int cyc = 0;
    always @(posedge clk_read) cyc <= cyc + 1;

    // FIFO model: initial block writes mem/wp, this block owns rp.
    logic [7:0] mem [0:511];
    int         wp = 0;
    int         rp = 0;
    logic       hold_empty = 1'b0;

    assign fifo_empty = hold_empty || (rp == wp);

    always @(posedge clk_read) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rp[8:0]];
            rp           <= rp + 1;
        end
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         pop_cnt = 0, xfer_cnt = 0, done_cnt = 0;
    int         first_xfer_cyc = -1, last_xfer_cyc = 0, done_cyc = 0;
    int         max_occ = 0;
    int         start_edge = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] held;
        logic       holding;
        logic [7:0] e;
        holding = 1'b0;
        held    = 8'h00;
        forever begin
            @(negedge clk_read);
            if (rst) begin
                holding = 1'b0;
                continue;
            end
            if (fifo_rd_en) begin
                pop_cnt++;
                check("rd_en_while_empty", int'(fifo_empty), 0);
            end
            if (holding) begin
                checks++;
                if (!strm.out_valid || strm.out_data != held) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b d=%02h expected v=1 d=%02h",
                             strm.out_valid, strm.out_data, held);
                end
            end
            holding = strm.out_valid && !strm.out_ready;
            held    = strm.out_data;
            if (strm.out_valid && strm.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_data: got %02h expected no transfer", strm.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (strm.out_data != e) begin
                        errors++;
                        $display("FAIL stream_data: got %02h expected %02h", strm.out_data, e);
                    end
                end
                xfer_cnt++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(dut.u_skid.occ) > max_occ) max_occ = int'(dut.u_skid.occ);
        end
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp[8:0]] = base + 8'(i);
            wp = wp + 1;
        end
    endtask

    task automatic expect_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
    endtask

    task automatic pulse_start(input logic [7:0] len);
        @(posedge clk_read); #1;
        start      = 1'b1;
        burst_len  = len;
        start_edge = cyc + 1;
        @(posedge clk_read); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk_read);
            n++;
        end
        check({name, "_done_timeout"}, int'(done), 1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!strm.out_valid && n < budget) begin
            @(negedge clk_read);
            n++;
        end
        check({name, "_valid_timeout"}, int'(strm.out_valid), 1);
    endtask

    initial begin
        int p0, x0, d0, stall_pops;

        rst            = 1'b1;
        start          = 1'b0;
        burst_len      = 8'd0;
        strm.out_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk_read);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        check("rst_valid", int'(strm.out_valid), 0);
        check("rst_data", int'(strm.out_data), 0);
        rst = 1'b0;

        // Back-to-back burst of 4
        preload(8'h10, 4);
        strm.out_ready = 1'b1;
        first_xfer_cyc = -1;
        x0 = xfer_cnt;
        expect_bytes(8'h10, 4);
        pulse_start(8'd4);
        wait_done("b2b", 40);
        @(negedge clk_read);
        check("b2b_first_latency", first_xfer_cyc - start_edge, 2);
        check("b2b_xfers", xfer_cnt - x0, 4);
        check("b2b_consecutive", last_xfer_cyc - first_xfer_cyc, 3);
        check("b2b_done_timing", done_cyc - last_xfer_cyc, 1);
        check("b2b_busy_after", int'(busy), 0);
        check("b2b_q_empty", exp_q.size(), 0);

        // burst_len = 0 -> 256 bytes
        preload(8'h00, 256);
        p0 = pop_cnt;
        x0 = xfer_cnt;
        expect_bytes(8'h00, 256);
        pulse_start(8'd0);
        wait_done("b256", 700);
        @(negedge clk_read);
        check("b256_pops", pop_cnt - p0, 256);
        check("b256_xfers", xfer_cnt - x0, 256);
        check("b256_q_empty", exp_q.size(), 0);

        // Backpressure: ready low for 10 cycles after first valid
        preload(8'h00, 6);
        strm.out_ready = 1'b0;
        expect_bytes(8'h00, 6);
        pulse_start(8'd6);
        wait_valid("bp", 20);
        p0 = pop_cnt;
        max_occ = 0;
        repeat (10) @(negedge clk_read);
        check("bp_stall_pops", pop_cnt - p0, 0);
        check("bp_occ_bound", int'(max_occ <= 2), 1);
        check("bp_occ_full", int'(dut.u_skid.occ), 2);
        @(posedge clk_read); #1;
        strm.out_ready = 1'b1;
        wait_done("bp", 40);
        @(negedge clk_read);
        check("bp_q_empty", exp_q.size(), 0);

        // Empty stall for 5 cycles mid-burst
        preload(8'h20, 8);
        p0 = pop_cnt;
        expect_bytes(8'h20, 8);
        pulse_start(8'd8);
        wait_valid("es", 20);
        @(posedge clk_read); #1;
        hold_empty = 1'b1;
        stall_pops = 0;
        repeat (5) begin
            @(negedge clk_read);
            if (fifo_rd_en) stall_pops++;
        end
        @(posedge clk_read); #1;
        hold_empty = 1'b0;
        check("es_stall_pops", stall_pops, 0);
        wait_done("es", 60);
        @(negedge clk_read);
        check("es_total_pops", pop_cnt - p0, 8);
        check("es_q_empty", exp_q.size(), 0);
`ifdef FIFO_RD_STATS_EN
        check("es_underrun", int'(underrun_cnt), 5);
`endif

        // Start while busy is ignored
        preload(8'h30, 6);
        p0 = pop_cnt;
        d0 = done_cnt;
        expect_bytes(8'h30, 6);
        pulse_start(8'd6);
        repeat (2) @(negedge clk_read);
        pulse_start(8'd9);
        wait_done("ign", 40);
        repeat (5) @(negedge clk_read);
        check("ign_done_pulses", done_cnt - d0, 1);
        check("ign_pops", pop_cnt - p0, 6);
        check("ign_busy", int'(busy), 0);
        check("ign_q_empty", exp_q.size(), 0);

        // Reset abort with 2 bytes buffered
        preload(8'h40, 6);
        strm.out_ready = 1'b0;
        pulse_start(8'd6);
        wait_valid("ra", 20);
        @(negedge clk_read);
        check("ra_buffered", int'(dut.u_skid.occ), 2);
        @(posedge clk_read); #1;
        rst = 1'b1;
        #1;
        check("ra_valid", int'(strm.out_valid), 0);
        check("ra_busy", int'(busy), 0);
        check("ra_rd_en", int'(fifo_rd_en), 0);
        @(posedge clk_read); #1;
        rst = 1'b0;
        strm.out_ready = 1'b1;
        // 0x40 and 0x41 were popped and discarded; the next burst sees 0x42.
        expect_bytes(8'h42, 2);
        x0 = xfer_cnt;
        pulse_start(8'd2);
        wait_done("ra", 40);
        @(negedge clk_read);
        check("ra_xfers", xfer_cnt - x0, 2);
        check("ra_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
